// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if : bundle between the multicycle control FSM and the datapath.
//
// master modport (controller side)
//   inputs : op[5:0], funct[5:0], zero, memready
//   outputs: memreq, memwrite, iord, irwrite, pcen, regwrite, regdst,
//            memtoreg, alusrca, alusrcb[1:0], aluop[1:0], signext,
//            shiftl16, pcsrc[1:0], link, err, state[3:0]
// slave modport (datapath side) sees the same signals with directions swapped.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;

    logic       memreq;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       signext;
    logic       shiftl16;
    logic [1:0] pcsrc;
    logic       link;
    logic       err;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, memready,
        output memreq, memwrite, iord, irwrite, pcen, regwrite, regdst,
               memtoreg, alusrca, alusrcb, aluop, signext, shiftl16,
               pcsrc, link, err, state
    );

    modport slave (
        output op, funct, zero, memready,
        input  memreq, memwrite, iord, irwrite, pcen, regwrite, regdst,
               memtoreg, alusrca, alusrcb, aluop, signext, shiftl16,
               pcsrc, link, err, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl : multicycle control FSM for the MIPS core. Sequences the shared
// ALU / register file / single-ported memory datapath over several cycles
// per instruction and flags a sticky error on illegal opcodes or when a
// memory access waits too long.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous, active-high; returns to FETCH, clears err
//   bus    : mc_ctrl_if.master (op/funct/zero/memready in, controls out)
//
// Parameters
//   WAIT_LIMIT : consecutive memory wait cycles tolerated before ERROR
//                (0 disables the timeout)
//
// Build option
//   MC_LINK_EN : when defined, adds JAL (op 000011) and JR (R-type funct
//                001000). When undefined, both decode to ERROR.
//
// States
//   state  | code | meaning
//   FETCH  |  0   | read instruction at PC, PC <= PC+4 on memready
//   DECODE |  1   | register read, precompute branch target
//   MEMADR |  2   | load/store effective address
//   MEMRD  |  3   | data memory read
//   MEMWB  |  4   | load writeback (rt <= MDR)
//   MEMWR  |  5   | data memory write
//   EXEC   |  6   | R-type ALU operation
//   ALUWB  |  7   | R-type writeback (rd)
//   BRANCH |  8   | BEQ/BNE compare, conditional PC load
//   IMMEX  |  9   | immediate ALU operation
//   IMMWB  | 10   | immediate writeback (rt)
//   JUMP   | 11   | PC <= jump target
//   JAL    | 12   | PC <= jump target, r31 <= PC (link build only)
//   JR     | 13   | PC <= rs (link build only)
//   ERROR  | 15   | sticky error, absorbing until reset
module mc_ctrl #(
    parameter int WAIT_LIMIT = 8
) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_ERROR  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Moore outputs, registered together with the state
    typedef struct packed {
        logic       memreq;
        logic       memwrite;
        logic       iord;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       signext;
        logic       shiftl16;
        logic [1:0] pcsrc;
        logic       link;
        logic       err;
    } ctrl_t;

    // Wait timer: loaded with WAIT_LIMIT on entry to a memory state and
    // counted down on each wait cycle; the wait cycle that sees it at 1 is
    // the WAIT_LIMIT-th one and raises the timeout.
    localparam int            TW       = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(WAIT_LIMIT);

    state_t        state;
    state_t        state_nx;
    ctrl_t         ctrl_q;
    logic [TW-1:0] wait_tmr;
    logic          waiting;
    logic          timeout;
    logic          pcen_m;

    function automatic logic is_mem(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

    function automatic ctrl_t decode_outs(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memreq  = 1'b1;
                c.alusrcb = 2'b01;
            end
            S_DECODE: begin
                c.alusrcb = 2'b11;
                c.signext = 1'b1;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.signext = 1'b1;
            end
            S_MEMRD: begin
                c.memreq = 1'b1;
                c.iord   = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                c.memreq   = 1'b1;
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b11;
            end
            S_ALUWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
            end
            S_IMMEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                case (op)
                    OP_ORI:  c.aluop    = 2'b10;
                    OP_LUI:  c.shiftl16 = 1'b1;
                    default: c.signext  = 1'b1;
                endcase
            end
            S_IMMWB: begin
                c.regwrite = 1'b1;
            end
            S_JUMP: begin
                c.pcsrc = 2'b10;
            end
`ifdef MC_LINK_EN
            S_JAL: begin
                c.pcsrc    = 2'b10;
                c.regwrite = 1'b1;
                c.link     = 1'b1;
            end
            S_JR: begin
                c.pcsrc = 2'b11;
            end
`endif
            S_ERROR: begin
                c.err = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    assign waiting = is_mem(state) && !bus.memready;
    assign timeout = (WAIT_LIMIT != 0) && waiting && (wait_tmr == TW'(1));

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: begin
                if (bus.memready)
                    state_nx = S_DECODE;
                else if (timeout)
                    state_nx = S_ERROR;
            end
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW:                       state_nx = S_MEMADR;
                    OP_RTYPE: begin
                        if (bus.funct == FN_JR)
`ifdef MC_LINK_EN
                            state_nx = S_JR;
`else
                            state_nx = S_ERROR;
`endif
                        else
                            state_nx = S_EXEC;
                    end
                    OP_BEQ, OP_BNE:                     state_nx = S_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI:  state_nx = S_IMMEX;
                    OP_J:                               state_nx = S_JUMP;
`ifdef MC_LINK_EN
                    OP_JAL:                             state_nx = S_JAL;
`endif
                    default:                            state_nx = S_ERROR;
                endcase
            end
            S_MEMADR: state_nx = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (bus.memready)
                    state_nx = S_MEMWB;
                else if (timeout)
                    state_nx = S_ERROR;
            end
            S_MEMWB:  state_nx = S_FETCH;
            S_MEMWR: begin
                if (bus.memready)
                    state_nx = S_FETCH;
                else if (timeout)
                    state_nx = S_ERROR;
            end
            S_EXEC:   state_nx = S_ALUWB;
            S_ALUWB:  state_nx = S_FETCH;
            S_BRANCH: state_nx = S_FETCH;
            S_IMMEX:  state_nx = S_IMMWB;
            S_IMMWB:  state_nx = S_FETCH;
            S_JUMP:   state_nx = S_FETCH;
`ifdef MC_LINK_EN
            S_JAL:    state_nx = S_FETCH;
            S_JR:     state_nx = S_FETCH;
`endif
            // ERROR and any unused code stay in / fall into ERROR
            default:  state_nx = S_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            ctrl_q   <= decode_outs(S_FETCH, bus.op);
            wait_tmr <= TMR_LOAD;
        end else begin
            state  <= state_nx;
            ctrl_q <= decode_outs(state_nx, bus.op);
            if (is_mem(state_nx) && (state_nx != state))
                wait_tmr <= TMR_LOAD;
            else if (waiting && (wait_tmr != '0))
                wait_tmr <= wait_tmr - 1'b1;
        end
    end

    // PC load and IR load react to memready/zero in the same cycle
    always_comb begin
        pcen_m = 1'b0;
        case (state)
            S_FETCH:  pcen_m = bus.memready;
            S_BRANCH: pcen_m = (bus.op == OP_BNE) ? !bus.zero : bus.zero;
            S_JUMP:   pcen_m = 1'b1;
`ifdef MC_LINK_EN
            S_JAL:    pcen_m = 1'b1;
            S_JR:     pcen_m = 1'b1;
`endif
            default:  pcen_m = 1'b0;
        endcase
    end

    assign bus.irwrite  = (state == S_FETCH) && bus.memready;
    assign bus.pcen     = pcen_m;
    assign bus.state    = state;

    assign bus.memreq   = ctrl_q.memreq;
    assign bus.memwrite = ctrl_q.memwrite;
    assign bus.iord     = ctrl_q.iord;
    assign bus.regwrite = ctrl_q.regwrite;
    assign bus.regdst   = ctrl_q.regdst;
    assign bus.memtoreg = ctrl_q.memtoreg;
    assign bus.alusrca  = ctrl_q.alusrca;
    assign bus.alusrcb  = ctrl_q.alusrcb;
    assign bus.aluop    = ctrl_q.aluop;
    assign bus.signext  = ctrl_q.signext;
    assign bus.shiftl16 = ctrl_q.shiftl16;
    assign bus.pcsrc    = ctrl_q.pcsrc;
    assign bus.link     = ctrl_q.link;
    assign bus.err      = ctrl_q.err;

endmodule
